dma_mmio_csr_responder: RTL
===========================

Name: dma_mmio_csr_responder

Overview:
- CCI-P MMIO responder for the DMA AFU. It decodes host-initiated MMIO reads and writes arriving on the c0 Rx channel, after the MPF shim.
- It returns read data on c2 Tx and holds the AFU device feature header (DFH), scratch registers and DMA control/status CSRs.
- The DFH chain points to the MPF feature chain at DFH_NEXT_OFFSET.
- Sits inside the user AFU, beside the DMA engine that consumes its control outputs.

Parameters:
AFU_ID_L, 64'h0, low 64 bits of AFU GUID (offset 0x008)
AFU_ID_H, 64'h0, high 64 bits of AFU GUID (offset 0x010)
DFH_NEXT_OFFSET, 24'h2000, byte offset to next DFH (MPF chain)
NUM_SCRATCH, 4, number of 64b scratch registers at 0x040 upward (1..4)

Ports:
Clk_400  in  1  CCI-P primary clock
SoftReset  in  1  asynchronous, active-high reset
mmio_rd_valid  in  1  MMIO read request valid
mmio_wr_valid  in  1  MMIO write request valid (never coincident with rd)
mmio_addr  in  16  MMIO address in 4B words (byte offset = addr<<2)
mmio_len  in  2  0=4B, 1=8B, 2=64B
mmio_tid  in  9  read transaction id
mmio_wdata  in  64  write data (4B writes use [31:0])
mmio_rsp_valid  out  1  c2 read response valid
mmio_rsp_tid  out  9  echoed tid
mmio_rsp_data  out  64  read data
dma_src  out  64  source address CSR
dma_dst  out  64  destination address CSR
dma_len  out  64  length CSR (bytes)
dma_start  out  1  one-cycle start pulse
dma_abort  out  1  one-cycle abort pulse
irq_en  out  1  interrupt enable
dma_status  in  64  engine status; bit0 = busy

Behaviour:
- Reset: all outputs 0; scratch, src, dst, len, irq_en and start_err cleared; cycle counter 0. In-flight reads are dropped with no response.
- Address map (byte offset; unlisted offsets read 0 and ignore writes):
  - 0x000 DFH RO: [63:60]=4'h1, [40]=0 (EOL), [39:16]=DFH_NEXT_OFFSET, rest 0.
  - 0x008 AFU_ID_L RO; 0x010 AFU_ID_H RO; 0x018 and 0x020 RO 0.
  - 0x040+8*i scratch RW, i<NUM_SCRATCH.
  - 0x060 CTRL: bit0 start (W1 pulse, reads 0); bit1 abort (W1 pulse, reads 0); bit8 irq_en RW; bit16 start_err (W1C).
  - 0x068 STATUS RO = dma_status.
  - 0x070 CYCLES RO: free-running 64b counter, wraps to 0.
  - 0x078 SRC, 0x080 DST, 0x088 LEN: RW.
- Read pipeline, fixed latency 3:
  - Request in cycle N gives mmio_rsp_valid=1 in cycle N+3 for exactly one cycle, tid echoed.
  - Stage 1 latches addr/len/tid; stage 2 muxes data; stage 3 registers outputs.
  - Back-to-back reads every cycle are supported. No backpressure exists on c2.
- 4B access:
  - Read returns the selected half (addr[0]=0 low, 1 high) in [31:0], with [63:32]=0.
  - Write updates only the selected half from wdata[31:0].
  - CTRL bits act on a 4B write with addr[0]=0.
- 64B (len=2): writes ignored, reads produce no response.
- Write in cycle N updates the register at the end of N. A read accepted in N+1 returns the new value.
- mmio_rsp_data is 0 whenever mmio_rsp_valid=0.
- Start:
  - Writing CTRL bit0=1 with dma_status[0]=0 gives dma_start=1 in N+1 only.
  - If dma_status[0]=1, there is no pulse and start_err is set (sticky until W1C).
  - If the same write sets bit0 and clears start_err, set wins.
- Abort: CTRL bit1=1 gives dma_abort=1 in N+1, unconditionally. Start and abort in the same write both pulse.
- CYCLES value is as sampled in stage 2.

Optional Feature:
- Macro DMA_MMIO_ACCESS_CNT_EN.
- Defined: adds RO 64b counters at 0x090 (MMIO reads accepted, len 0/1) and 0x098 (MMIO writes accepted). Both reset to 0 and saturate at all-ones. Writes to 0x090 or 0x098 clear both counters.
- Undefined: 0x090 and 0x098 read 0, and no counter logic exists.

Decomposition:
- Package dma_csr_pkg holds:
  - byte-offset constants (DFH, AFU_ID_L/H, SCRATCH_BASE, CTRL, STATUS, CYCLES, SRC, DST, LEN, RD_CNT, WR_CNT);
  - CTRL bit-position constants;
  - DFH field localparams (type, EOL bit);
  - t_mmio_len enum.
- Sub-module dma_mmio_rd_pipe: the 3-stage read return (valid/tid/addr shift plus registered data). The top contains the register file and decode.

Test Plan:
- Reset, then read 0x000 (addr 16'h0, len 1, tid 9'h05) -> 3 cycles later rsp_valid=1, tid=5, data=64'h1000_0000_2000_0000.
- 8B write 0x040=64'hDEAD_BEEF_0123_4567, then 4B read addr 16'h11 -> data 64'h0000_0000_DEAD_BEEF. 4B write addr 16'h10 = 32'h0 -> 8B read gives 64'hDEAD_BEEF_0000_0000.
- Write CTRL=1 with dma_status=0 -> dma_start high exactly 1 cycle. Repeat with dma_status=1 -> no pulse, CTRL read bit16=1. Write CTRL=32'h1_0000 -> bit16 reads 0.
- Reads on 8 consecutive cycles with tids 0..7 -> 8 consecutive responses, tids 0..7 in order, each at +3.
- Write SRC in cycle N, read SRC in N+1 -> new value. Read with len=2 -> no response within 10 cycles. Assert SoftReset with 2 reads in flight -> no responses, and SRC reads 0 afterward.
- With DMA_MMIO_ACCESS_CNT_EN: 3 reads and 2 writes, then read 0x090 -> 3 (the read of 0x090 itself is counted after sampling) and read 0x098 -> 2.

Source files
------------

// File: rtl/dma_csr_pkg.sv
// Shared constants and types for the DMA AFU MMIO CSR responder.
// Offsets are CSR byte offsets; MMIO addresses arrive in 4B words.
package dma_csr_pkg;

    localparam logic [17:0] CSR_DFH          = 18'h000;
    localparam logic [17:0] CSR_AFU_ID_L     = 18'h008;
    localparam logic [17:0] CSR_AFU_ID_H     = 18'h010;
    localparam logic [17:0] CSR_SCRATCH_BASE = 18'h040;
    localparam logic [17:0] CSR_CTRL         = 18'h060;
    localparam logic [17:0] CSR_STATUS       = 18'h068;
    localparam logic [17:0] CSR_CYCLES       = 18'h070;
    localparam logic [17:0] CSR_SRC          = 18'h078;
    localparam logic [17:0] CSR_DST          = 18'h080;
    localparam logic [17:0] CSR_LEN          = 18'h088;
    localparam logic [17:0] CSR_RD_CNT       = 18'h090;
    localparam logic [17:0] CSR_WR_CNT       = 18'h098;

    localparam int unsigned CTRL_START     = 0;
    localparam int unsigned CTRL_ABORT     = 1;
    localparam int unsigned CTRL_IRQ_EN    = 8;
    localparam int unsigned CTRL_START_ERR = 16;

    localparam logic [3:0] DFH_TYPE_AFU = 4'h1;
    localparam logic       DFH_EOL      = 1'b0;

    typedef enum logic [1:0] {
        LEN_4B  = 2'd0,
        LEN_8B  = 2'd1,
        LEN_64B = 2'd2
    } t_mmio_len;

    // Byte offset of the 8B register that contains a 4B-word address.
    function automatic logic [17:0] qword_offset(input logic [15:1] addr);
        return {addr, 3'b000};
    endfunction

    function automatic logic [63:0] merge_write(input logic [63:0] old, input logic [63:0] wdata,
                                                input logic is_4b, input logic hi);
        if (!is_4b) return wdata;
        return hi ? {wdata[31:0], old[31:0]} : {old[63:32], wdata[31:0]};
    endfunction

endpackage

// File: rtl/dma_mmio_csr_responder_if.sv
// CCI-P MMIO request (c0 Rx) and read response (c2 Tx) bundle.
interface dma_mmio_csr_responder_if;

    logic        mmio_rd_valid;
    logic        mmio_wr_valid;
    logic [15:0] mmio_addr;
    logic [1:0]  mmio_len;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wdata;
    logic        mmio_rsp_valid;
    logic [8:0]  mmio_rsp_tid;
    logic [63:0] mmio_rsp_data;

    modport master (
        output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
        input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
    );

    modport slave (
        input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
        output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
    );

endinterface

// File: rtl/dma_mmio_rd_pipe.sv
// Fixed-latency (3) MMIO read return: stage 1 latches the request, stage 2 captures
// the data muxed by the parent from the stage-1 address, stage 3 drives c2.
module dma_mmio_rd_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    input  logic [1:0]  req_len,
    input  logic [8:0]  req_tid,
    output logic        s1_valid,
    output logic [15:0] s1_addr,
    output logic [1:0]  s1_len,
    input  logic [63:0] s1_data,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data
);

    logic [8:0]  s1_tid;
    logic        s2_valid;
    logic [8:0]  s2_tid;
    logic [63:0] s2_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_len    <= '0;
            s1_tid    <= '0;
            s2_valid  <= 1'b0;
            s2_tid    <= '0;
            s2_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            s1_valid  <= req_valid;
            s1_addr   <= req_addr;
            s1_len    <= req_len;
            s1_tid    <= req_tid;
            s2_valid  <= s1_valid;
            s2_tid    <= s1_tid;
            s2_data   <= s1_valid ? s1_data : '0;
            rsp_valid <= s2_valid;
            rsp_tid   <= s2_tid;
            // Data bus is held at zero whenever no response is presented.
            rsp_data  <= s2_valid ? s2_data : '0;
        end
    end

endmodule

// File: rtl/dma_mmio_csr_responder.sv
// CCI-P MMIO CSR responder for the DMA AFU: DFH, scratch, DMA control/status CSRs.
// Optional read/write access counters at 0x090/0x098 under DMA_MMIO_ACCESS_CNT_EN.
module dma_mmio_csr_responder
    import dma_csr_pkg::*;
#(
    parameter logic [63:0] AFU_ID_L        = 64'h0,
    parameter logic [63:0] AFU_ID_H        = 64'h0,
    parameter logic [23:0] DFH_NEXT_OFFSET = 24'h2000,
    parameter int unsigned NUM_SCRATCH     = 4
) (
    input  logic                           Clk_400,
    input  logic                           SoftReset,
    dma_mmio_csr_responder_if.slave        mmio,
    output logic [63:0]                    dma_src,
    output logic [63:0]                    dma_dst,
    output logic [63:0]                    dma_len,
    output logic                           dma_start,
    output logic                           dma_abort,
    output logic                           irq_en,
    input  logic [63:0]                    dma_status
);

    localparam logic [63:0] DFH_VALUE = {DFH_TYPE_AFU, 19'b0, DFH_EOL, DFH_NEXT_OFFSET, 16'b0};

    logic [63:0] scratch_q [NUM_SCRATCH];
    logic [63:0] cycles_q;
    logic        start_err_q;

    t_mmio_len   wr_len;
    logic        wr_en;
    logic        wr_4b;
    logic        wr_hi;
    logic [17:0] wr_qaddr;
    logic        ctrl_wr;

    logic        s1_valid;
    logic [15:0] s1_addr;
    logic [1:0]  s1_len;
    logic [17:0] rd_qaddr;
    logic [63:0] rd_qword;
    logic [63:0] rd_data;

    assign wr_len   = t_mmio_len'(mmio.mmio_len);
    assign wr_en    = mmio.mmio_wr_valid && (wr_len != LEN_64B);
    assign wr_4b    = (wr_len == LEN_4B);
    assign wr_hi    = mmio.mmio_addr[0];
    assign wr_qaddr = qword_offset(mmio.mmio_addr[15:1]);
    // CTRL bits all live in the low half, so an upper-half 4B write does nothing.
    assign ctrl_wr  = wr_en && (wr_qaddr == CSR_CTRL) && !(wr_4b && wr_hi);

    always_ff @(posedge Clk_400 or posedge SoftReset) begin
        if (SoftReset) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
            cycles_q    <= '0;
            start_err_q <= 1'b0;
            dma_src     <= '0;
            dma_dst     <= '0;
            dma_len     <= '0;
            dma_start   <= 1'b0;
            dma_abort   <= 1'b0;
            irq_en      <= 1'b0;
        end else begin
            cycles_q  <= cycles_q + 64'd1;
            dma_start <= ctrl_wr && mmio.mmio_wdata[CTRL_START] && !dma_status[0];
            dma_abort <= ctrl_wr && mmio.mmio_wdata[CTRL_ABORT];
            if (ctrl_wr) begin
                irq_en <= mmio.mmio_wdata[CTRL_IRQ_EN];
                // A refused start sets the sticky error even if the same write clears it.
                if (mmio.mmio_wdata[CTRL_START] && dma_status[0]) begin
                    start_err_q <= 1'b1;
                end else if (mmio.mmio_wdata[CTRL_START_ERR]) begin
                    start_err_q <= 1'b0;
                end
            end
            if (wr_en) begin
                if (wr_qaddr == CSR_SRC) dma_src <= merge_write(dma_src, mmio.mmio_wdata, wr_4b, wr_hi);
                if (wr_qaddr == CSR_DST) dma_dst <= merge_write(dma_dst, mmio.mmio_wdata, wr_4b, wr_hi);
                if (wr_qaddr == CSR_LEN) dma_len <= merge_write(dma_len, mmio.mmio_wdata, wr_4b, wr_hi);
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (wr_qaddr == CSR_SCRATCH_BASE + 18'(8 * i)) begin
                        scratch_q[i] <= merge_write(scratch_q[i], mmio.mmio_wdata, wr_4b, wr_hi);
                    end
                end
            end
        end
    end

`ifdef DMA_MMIO_ACCESS_CNT_EN
    logic [63:0] rd_cnt_q;
    logic [63:0] wr_cnt_q;
    logic        cnt_clr;

    assign cnt_clr = wr_en && ((wr_qaddr == CSR_RD_CNT) || (wr_qaddr == CSR_WR_CNT));

    // Reads count as they leave stage 1, after their own data has been sampled.
    always_ff @(posedge Clk_400 or posedge SoftReset) begin
        if (SoftReset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (cnt_clr) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (s1_valid && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 64'd1;
            if (wr_en && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 64'd1;
        end
    end
`endif

    assign rd_qaddr = qword_offset(s1_addr[15:1]);

    always_comb begin
        rd_qword = '0;
        case (rd_qaddr)
            CSR_DFH:      rd_qword = DFH_VALUE;
            CSR_AFU_ID_L: rd_qword = AFU_ID_L;
            CSR_AFU_ID_H: rd_qword = AFU_ID_H;
            CSR_CTRL: begin
                rd_qword[CTRL_IRQ_EN]    = irq_en;
                rd_qword[CTRL_START_ERR] = start_err_q;
            end
            CSR_STATUS:   rd_qword = dma_status;
            CSR_CYCLES:   rd_qword = cycles_q;
            CSR_SRC:      rd_qword = dma_src;
            CSR_DST:      rd_qword = dma_dst;
            CSR_LEN:      rd_qword = dma_len;
`ifdef DMA_MMIO_ACCESS_CNT_EN
            CSR_RD_CNT:   rd_qword = rd_cnt_q;
            CSR_WR_CNT:   rd_qword = wr_cnt_q;
`endif
            default:      rd_qword = '0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (rd_qaddr == CSR_SCRATCH_BASE + 18'(8 * i)) rd_qword = scratch_q[i];
        end
    end

    always_comb begin
        rd_data = rd_qword;
        if (s1_len == LEN_4B) begin
            rd_data = s1_addr[0] ? {32'b0, rd_qword[63:32]} : {32'b0, rd_qword[31:0]};
        end
    end

    dma_mmio_rd_pipe u_rd_pipe (
        .clk       (Clk_400),
        .rst       (SoftReset),
        .req_valid (mmio.mmio_rd_valid && (mmio.mmio_len != LEN_64B)),
        .req_addr  (mmio.mmio_addr),
        .req_len   (mmio.mmio_len),
        .req_tid   (mmio.mmio_tid),
        .s1_valid  (s1_valid),
        .s1_addr   (s1_addr),
        .s1_len    (s1_len),
        .s1_data   (rd_data),
        .rsp_valid (mmio.mmio_rsp_valid),
        .rsp_tid   (mmio.mmio_rsp_tid),
        .rsp_data  (mmio.mmio_rsp_data)
    );

endmodule
